// File: rtl/rv_decode_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate-kind encoding and the
// buffered entry layout used by instr_imm_field_stage.
// Optional feature macro: INSTR_IMM_ILLEGAL_EN (adds the illegal flag to entries).
package rv_decode_pkg;

  localparam int unsigned XLEN = 32;

  // Major opcodes, instr[6:0]
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Immediate kind seen by the downstream 20->32 extender
  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_kind_e;

  // One buffered instruction with its decode results captured at accept time
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [19:0]     imm20;
    imm_kind_e       kind;
    logic [4:0]      rd;
`ifdef INSTR_IMM_ILLEGAL_EN
    logic            illegal;
`endif
  } entry_t;

  // Sign-extend a 12-bit field into the 20-bit output field
  function automatic logic [19:0] sext12_to_20(input logic [11:0] v);
    return {{8{v[11]}}, v};
  endfunction

endpackage

// File: rtl/imm_field_pack.sv
// Combinational RV32I immediate-field extractor: instruction word in,
// raw 20-bit signed field, immediate kind and destination register out.
module imm_field_pack
  import rv_decode_pkg::*;
(
  input  logic [XLEN-1:0] i_instr,
  output logic [19:0]     o_imm20,
  output imm_kind_e       o_kind,
  output logic [4:0]      o_rd
);

  imm_kind_e w_kind;

  // Classify the instruction format from its major opcode
  always_comb begin
    w_kind = IMM_NONE;
    case (i_instr[6:0])
      OPC_OPIMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: w_kind = IMM_I;
      OPC_STORE:                                 w_kind = IMM_S;
      OPC_BRANCH:                                w_kind = IMM_B;
      OPC_LUI, OPC_AUIPC:                        w_kind = IMM_U;
      OPC_JAL:                                   w_kind = IMM_J;
      default:                                   w_kind = IMM_NONE;
    endcase
  end

  // Gather the scattered immediate bits; B and J keep imm[12:1]/imm[20:1]
  always_comb begin
    o_imm20 = '0;
    o_rd    = i_instr[11:7];
    case (w_kind)
      IMM_I: o_imm20 = sext12_to_20(i_instr[31:20]);
      IMM_S: begin
        o_imm20 = sext12_to_20({i_instr[31:25], i_instr[11:7]});
        o_rd    = '0;
      end
      IMM_B: begin
        o_imm20 = sext12_to_20({i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8]});
        o_rd    = '0;
      end
      IMM_U: o_imm20 = i_instr[31:12];
      IMM_J: o_imm20 = {i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21]};
      default: o_imm20 = '0;
    endcase
  end

  assign o_kind = w_kind;

endmodule

// File: rtl/instr_imm_field_stage.sv
// Registered decode-side stage: two-entry skid buffer (main + skid) holding
// fetched RV32I instructions together with their immediate field decode.
// in_ready is registered (no combinational path from out_ready).
// Optional feature macro: INSTR_IMM_ILLEGAL_EN (adds out_illegal).
module instr_imm_field_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SKID_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [19:0]     out_imm20,
  output logic [2:0]      out_imm_kind,
  output logic [4:0]      out_rd
`ifdef INSTR_IMM_ILLEGAL_EN
  ,
  output logic            out_illegal
`endif
);

  import rv_decode_pkg::*;

  entry_t r_main;
  entry_t r_skid;
  logic   r_main_valid;
  logic   r_skid_valid;

  entry_t                w_new;
  logic [19:0]           w_imm20;
  imm_kind_e             w_kind;
  logic [4:0]            w_rd;
  logic [SKID_DEPTH-1:0] w_occ;
  logic                  w_accept;
  logic                  w_consume;

  imm_field_pack u_pack (
    .i_instr (in_instr),
    .o_imm20 (w_imm20),
    .o_kind  (w_kind),
    .o_rd    (w_rd)
  );

  // Assemble the entry written on accept; decode is captured here, not at the output
  always_comb begin
    w_new       = '0;
    w_new.instr = in_instr;
    w_new.pc    = in_pc;
    w_new.imm20 = w_imm20;
    w_new.kind  = w_kind;
    w_new.rd    = w_rd;
`ifdef INSTR_IMM_ILLEGAL_EN
    w_new.illegal = ((w_kind == IMM_NONE) && (in_instr[6:0] != OPC_OP) &&
                     (in_instr[6:0] != OPC_FENCE)) || (in_instr[1:0] != 2'b11);
`endif
  end

  // Occupancy: bit 0 = main entry, top bit = skid entry
  assign w_occ     = {r_skid_valid, r_main_valid};
  assign in_ready  = ~w_occ[SKID_DEPTH-1];
  assign out_valid = w_occ[0];
  assign w_accept  = in_valid & in_ready;
  assign w_consume = r_main_valid & out_ready;

  // Buffer update: main refills from skid first, else from the input; the
  // skid entry only loads when main is held and a new word is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_main_valid || w_consume) begin
      if (r_skid_valid) begin
        r_main       <= r_skid;
        r_main_valid <= 1'b1;
        r_skid_valid <= 1'b0;
      end else begin
        r_main_valid <= w_accept;
        if (w_accept) begin
          r_main <= w_new;
        end
      end
    end else if (w_accept) begin
      r_skid       <= w_new;
      r_skid_valid <= 1'b1;
    end
  end

  assign out_instr    = r_main.instr;
  assign out_pc       = r_main.pc;
  assign out_imm20    = r_main.imm20;
  assign out_imm_kind = r_main.kind;
  assign out_rd       = r_main.rd;
`ifdef INSTR_IMM_ILLEGAL_EN
  assign out_illegal  = r_main.illegal;
`endif

endmodule

// File: tb/tb_instr_imm_field_stage.sv
// Self-checking bench for instr_imm_field_stage: directed format vectors,
// backpressure, flush, asynchronous reset and randomized traffic compared
// against a FIFO-of-two reference with ISA-level immediate semantics.
module tb_instr_imm_field_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [19:0] out_imm20;
  logic [2:0]  out_imm_kind;
  logic [4:0]  out_rd;
`ifdef INSTR_IMM_ILLEGAL_EN
  logic        out_illegal;
`endif

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } txn_t;

  txn_t q[$];
  int   n_checks;
  int   n_errors;

  instr_imm_field_stage #(.XLEN(32), .SKID_DEPTH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .out_imm20    (out_imm20),
    .out_imm_kind (out_imm_kind),
    .out_rd       (out_rd)
`ifdef INSTR_IMM_ILLEGAL_EN
    ,
    .out_illegal  (out_illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: ISA kind, full 32-bit immediate and rd for an instruction
  function automatic void ref_decode(input logic [31:0] ins, output logic [2:0] kind,
                                     output logic [31:0] imm, output logic [4:0] rd);
    logic [6:0] opc;
    opc  = ins[6:0];
    kind = 3'd0;
    imm  = 32'h0;
    rd   = ins[11:7];
    case (opc)
      7'h13, 7'h03, 7'h67, 7'h73: begin
        kind = 3'd1; imm = {{20{ins[31]}}, ins[31:20]};
      end
      7'h23: begin
        kind = 3'd2; imm = {{20{ins[31]}}, ins[31:25], ins[11:7]}; rd = 5'd0;
      end
      7'h63: begin
        kind = 3'd3; imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; rd = 5'd0;
      end
      7'h37, 7'h17: begin
        kind = 3'd4; imm = {ins[31:12], 12'h000};
      end
      7'h6F: begin
        kind = 3'd5; imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      default: ;
    endcase
  endfunction

  // Consumer contract: rebuild the 32-bit immediate from the emitted field
  function automatic logic [31:0] recon(input logic [2:0] kind, input logic [19:0] f);
    case (kind)
      3'd1, 3'd2: return {{12{f[19]}}, f};
      3'd3, 3'd5: return {{11{f[19]}}, f, 1'b0};
      3'd4:       return {f, 12'h000};
      default:    return {12'h000, f};
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  opcs [12];
    logic [31:0] r;
    int unsigned k;
    opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h2B};
    r = $urandom();
    k = $urandom_range(0, 12);
    if (k < 12) r[6:0] = opcs[k];
    return r;
  endfunction

  // Advance one clock edge, updating the FIFO-of-two reference, then settle
  task automatic tick();
    bit cons, acc;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
    end else begin
      cons = (q.size() > 0) && out_ready;
      acc  = in_valid && (q.size() < 2);
      if (flush) begin
        q.delete();
      end else begin
        if (cons) void'(q.pop_front());
        if (acc) q.push_back('{in_instr, in_pc});
      end
    end
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'h0; in_pc = 32'h0;
    #2;
    n_checks++;
    if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_imm20 !== 20'h0 ||
        out_imm_kind !== 3'd0 || out_rd !== 5'd0 || out_pc !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_hold: valid=%b instr=%h imm=%h kind=%0d rd=%0d, required 0s",
               out_valid, out_instr, out_imm20, out_imm_kind, out_rd);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_release: valid=%b ready=%b, required valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_formats();
    logic [31:0] vi [4];
    logic [19:0] vimm [4];
    logic [2:0]  vk [4];
    logic [4:0]  vrd [4];
    vi   = '{32'h123450B7, 32'h0080006F, 32'hFFF00093, 32'hFE000EE3};
    vimm = '{20'h12345, 20'h00004, 20'hFFFFF, 20'hFFFFE};
    vk   = '{3'd4, 3'd5, 3'd1, 3'd3};
    vrd  = '{5'd1, 5'd0, 5'd1, 5'd0};
    drain();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_instr = vi[i]; in_pc = 32'h1000 + 32'(4 * i);
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || out_imm20 !== vimm[i] || out_imm_kind !== vk[i] ||
          out_rd !== vrd[i] || out_instr !== vi[i] || out_pc !== 32'h1000 + 32'(4 * i)) begin
        n_errors++;
        $display("FAIL format_%0d: valid=%b imm=%h kind=%0d rd=%0d instr=%h, required imm=%h kind=%0d rd=%0d instr=%h",
                 i, out_valid, out_imm20, out_imm_kind, out_rd, out_instr, vimm[i], vk[i], vrd[i], vi[i]);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL format_drain_%0d: valid=%b, required 0", i, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, c;
    a = 32'h00A00513; b = 32'h00B00593; c = 32'h00C00613;
    drain();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = a; in_pc = 32'h200;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_instr !== a || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_a: valid=%b instr=%h ready=%b, required 1/%h/1", out_valid, out_instr, in_ready, a);
    end
    in_instr = b; in_pc = 32'h204;
    tick();
    n_checks++;
    if (in_ready !== 1'b0 || out_instr !== a) begin
      n_errors++;
      $display("FAIL bp_b_skid: ready=%b instr=%h, required 0/%h", in_ready, out_instr, a);
    end
    in_instr = c; in_pc = 32'h208;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_instr !== a || out_pc !== 32'h200 ||
          out_imm20 !== 20'h0000A || out_imm_kind !== 3'd1 || out_rd !== 5'd10) begin
        n_errors++;
        $display("FAIL bp_stall_%0d: ready=%b instr=%h pc=%h imm=%h rd=%0d, required 0/%h/200/0000a/10",
                 k, in_ready, out_instr, out_pc, out_imm20, out_rd, a);
      end
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_instr !== b || out_pc !== 32'h204 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_out_b: valid=%b instr=%h ready=%b, required 1/%h/1", out_valid, out_instr, in_ready, b);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_instr !== c || out_pc !== 32'h208 || out_imm20 !== 20'h0000C) begin
      n_errors++;
      $display("FAIL bp_out_c: valid=%b instr=%h imm=%h, required 1/%h/0000c", out_valid, out_instr, out_imm20, c);
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_empty: valid=%b, required 0 (no duplicate)", out_valid);
    end
  endtask

  task automatic test_flush();
    drain();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h300;
    tick();
    in_instr = 32'h00200113; in_pc = 32'h304;
    tick();
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_full: ready=%b, required 0", in_ready);
    end
    flush = 1'b1; in_instr = 32'h00300193; in_pc = 32'h308;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL flush_full_after: valid=%b ready=%b, required 0/1", out_valid, in_ready);
    end
    // one entry held, flush while a new word would be accepted
    in_valid = 1'b1; in_instr = 32'h00400213; in_pc = 32'h30C;
    tick();
    flush = 1'b1; in_instr = 32'h00500293; in_pc = 32'h310;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_errors++;
        $display("FAIL flush_gone_%0d: valid=%b ready=%b instr=%h, required 0/1", k, out_valid, in_ready, out_instr);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    drain();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00600313; in_pc = 32'h400;
    tick();
    in_instr = 32'h00700393; in_pc = 32'h404;
    tick();
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    q.delete();
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_instr !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_async: valid=%b ready=%b instr=%h, required 0/1/0", out_valid, in_ready, out_instr);
    end
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_mid_after: valid=%b ready=%b, required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_random();
    logic [2:0]  ek;
    logic [31:0] eimm;
    logic [4:0]  erd;
    bit          ev, er;
    drain();
    for (int c = 0; c < 2500; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 39) == 0);
      in_instr  = rand_instr();
      in_pc     = $urandom();
      tick();
      ev = (q.size() > 0);
      er = (q.size() < 2);
      n_checks++;
      if (out_valid !== ev || in_ready !== er) begin
        n_errors++;
        $display("FAIL rand_hs cycle %0d: valid=%b ready=%b, required %b/%b", c, out_valid, in_ready, ev, er);
      end
      if (ev) begin
        ref_decode(q[0].instr, ek, eimm, erd);
        n_checks++;
        if (out_instr !== q[0].instr || out_pc !== q[0].pc || out_imm_kind !== ek ||
            out_rd !== erd || recon(out_imm_kind, out_imm20) !== eimm) begin
          n_errors++;
          $display("FAIL rand_data cycle %0d: instr=%h pc=%h kind=%0d imm20=%h rd=%0d, required instr=%h pc=%h kind=%0d imm32=%h rd=%0d",
                   c, out_instr, out_pc, out_imm_kind, out_imm20, out_rd, q[0].instr, q[0].pc, ek, eimm, erd);
        end
`ifdef INSTR_IMM_ILLEGAL_EN
        n_checks++;
        if (out_illegal !== (((ek == 3'd0) && (q[0].instr[6:0] != 7'h33) && (q[0].instr[6:0] != 7'h0F)) ||
                             (q[0].instr[1:0] != 2'b11))) begin
          n_errors++;
          $display("FAIL rand_illegal cycle %0d: illegal=%b instr=%h", c, out_illegal, q[0].instr);
        end
`endif
      end
    end
    flush = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_formats();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
